// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = x - y - bin, one bit per clock, LSB first.
// A single borrow flop replaces the ripple chain; results and flags appear together with done.
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             xmsb_q, xmsb_d;
  logic             ymsb_q, ymsb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zf_q, zf_d;
  logic             nf_q, nf_d;
  logic             vf_q, vf_d;

  logic             d_bit;
  logic             borrow_nx;

  // One full-subtractor slice applied to the current LSBs.
  assign d_bit     = xs_q[0] ^ ys_q[0] ^ borrow_q;
  assign borrow_nx = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & borrow_q);

  always_comb begin
    state_d  = state_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    xmsb_d   = xmsb_q;
    ymsb_d   = ymsb_q;
    busy_d   = busy_q;
    done_d   = done_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    vf_d     = vf_q;

    case (state_q)
      // The done cycle also accepts a new request so back-to-back ops start WIDTH+1 edges apart.
      IDLE, DONE: begin
        done_d = 1'b0;
        if (start) begin
          xs_d     = x;
          ys_d     = y;
          borrow_d = bin;
          xmsb_d   = x[WIDTH-1];
          ymsb_d   = y[WIDTH-1];
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end

      RUN: begin
        xs_d     = xs_q >> 1;
        ys_d     = ys_q >> 1;
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Flags use the captured operand MSBs, never the live inputs.
          diff_d  = res_d;
          bout_d  = borrow_nx;
          zf_d    = (res_d == '0);
          nf_d    = d_bit;
          vf_d    = (xmsb_q ^ ymsb_q) & (xmsb_q ^ d_bit);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      xs_q     <= '0;
      ys_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      xmsb_q   <= 1'b0;
      ymsb_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      vf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      xmsb_q   <= xmsb_d;
      ymsb_q   <= ymsb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      vf_q     <= vf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zf   = zf_q;
  assign nf   = nf_q;
  assign vf   = vf_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Bench for serial_subtractor_8bit: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results.
module tb_serial_subtractor_8bit;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x, y;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         bout, zf, nf, vf;

  int n_total = 0;
  int n_pass  = 0;
  logic check_en = 1'b0;

  serial_subtractor_8bit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .x    (x),
    .y    (y),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .zf   (zf),
    .nf   (nf),
    .vf   (vf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: transaction-level, counts down WIDTH edges then publishes x - y - bin.
  logic         m_busy, m_done;
  int           m_left;
  logic [W-1:0] m_x, m_y;
  logic         m_bin;
  logic [W-1:0] m_diff;
  logic         m_bout, m_zf, m_nf, m_vf;

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int r;
    r = int'(a) - int'(b) - int'(c);
    return W'(r + (1 << W));
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return int'(a) < (int'(b) + int'(c));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
      m_x <= '0; m_y <= '0; m_bin <= 1'b0;
      m_diff <= '0; m_bout <= 1'b0; m_zf <= 1'b0; m_nf <= 1'b0; m_vf <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_diff <= ref_diff(m_x, m_y, m_bin);
        m_bout <= ref_bout(m_x, m_y, m_bin);
        m_zf   <= (ref_diff(m_x, m_y, m_bin) == 0);
        m_nf   <= ref_diff(m_x, m_y, m_bin) >= W'(1 << (W - 1));
        m_vf   <= (m_x[W-1] != m_y[W-1]) && (ref_diff(m_x, m_y, m_bin) [W-1] != m_x[W-1]);
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_x <= x; m_y <= y; m_bin <= bin;
        m_busy <= 1'b1;
        m_left <= W;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en)
      chk("cycle {busy,done,diff,bout,zf,nf,vf}",
          {20'd0, busy, done, diff, bout, zf, nf, vf},
          {20'd0, m_busy, m_done, m_diff, m_bout, m_zf, m_nf, m_vf});
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] ed, input logic eb, input logic ez,
                       input logic en, input logic ev, input string nm);
    int lat;
    @(posedge clk); #2;
    x = a; y = b; bin = c; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    chk({nm, " latency"}, lat, 8);
    chk({nm, " diff"}, {24'd0, diff}, {24'd0, ed});
    chk({nm, " bout"}, {31'd0, bout}, {31'd0, eb});
    chk({nm, " zf"}, {31'd0, zf}, {31'd0, ez});
    chk({nm, " nf"}, {31'd0, nf}, {31'd0, en});
    chk({nm, " vf"}, {31'd0, vf}, {31'd0, ev});
    $display("op %s: x=%02h y=%02h bin=%0d -> diff=%02h bout=%0d z=%0d n=%0d v=%0d",
             nm, a, b, c, diff, bout, zf, nf, vf);
  endtask

  initial begin
    int n_done, i0, i1;
    logic [W-1:0] d0, d1;
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy/done/diff/flags", {20'd0, busy, done, diff, bout, zf, nf, vf}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    check_en = 1'b1;

    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, "5-3");
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, "0-1");
    do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, "0-0-bin");
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, "80-01");
    do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, "7F-FF");
    do_op(8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "10-10");
    repeat (20) @(negedge clk);
    chk("hold after idle diff/zf", {23'd0, diff, zf}, {23'd0, 8'h00, 1'b1});

    // Start held high; operands change mid-run and are picked up only at the next accept.
    @(posedge clk); #2;
    x = 8'h33; y = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    n_done = 0; i0 = -1; i1 = -1; d0 = '0; d1 = '0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (i == 2) begin x = 8'h01; y = 8'h02; end
      if (done) begin
        if (n_done == 0) begin i0 = i; d0 = diff; end
        if (n_done == 1) begin i1 = i; d1 = diff; end
        n_done++;
      end
    end
    start = 1'b0;
    chk("held first done index", i0, 8);
    chk("held second done index", i1, 17);
    chk("held first diff", {24'd0, d0}, 32'h22);
    chk("held second diff", {24'd0, d1}, 32'hFF);
    chk("held done count", n_done, 3);
    $display("held-start: dones=%0d at %0d,%0d diffs=%02h,%02h", n_done, i0, i1, d0, d1);
    repeat (12) @(negedge clk);

    // Asynchronous abort in the middle of a run.
    @(posedge clk); #2;
    x = 8'h12; y = 8'h34; bin = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy before abort", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort immediate outputs", {20'd0, busy, done, diff, bout, zf, nf, vf}, 32'd0);
    $display("abort: busy=%0d done=%0d diff=%02h", busy, done, diff);
    @(posedge clk); #2;
    rst_n = 1'b1;
    do_op(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b1, "A5-5A");

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 2) == 0);
      x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
      @(negedge clk);
      if (done) $display("rand done: diff=%02h bout=%0d z=%0d n=%0d v=%0d", diff, bout, zf, nf, vf);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
